stim_sequencer: RTL

- Downstream of the majority-vote seizure controller.
- Consumes its per-window stimulation decision and vote count.
- Debounces the decision over consecutive feature windows, then generates a timed biphasic pulse train for the stimulator driver, followed by a refractory lockout.
- Sequential replacement for using the raw combinational stimulation flag directly.

---
 rtl/stim_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/stim_sequencer.sv
// Debounced biphasic stimulation sequencer: confirms consecutive positive decisions,
// then plays a timed pos/gap/neg pulse train and a refractory lockout. Optional macro: STIM_FASTPATH_EN.
module stim_sequencer #(
  parameter int unsigned CONFIRM_N = 3,
  parameter int unsigned PULSE_W   = 8,
  parameter int unsigned GAP_W     = 4,
  parameter int unsigned PULSE_CNT = 4,
  parameter int unsigned IPI_W     = 32,
  parameter int unsigned REFRACT_W = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        decision_valid,
  input  logic        stimulation,
  input  logic [1:0]  count,
  output logic        stim_pos,
  output logic        stim_neg,
  output logic        busy,
  output logic        train_done,
  output logic [15:0] train_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIRM, S_POS, S_GAP, S_NEG, S_IPI, S_REFRACT
  } state_t;

  state_t      r_state;
  logic [15:0] r_timer;
  logic [3:0]  r_confirm;
  logic [7:0]  r_pulse;
  logic        r_pos;
  logic        r_neg;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_train_count;

  logic w_pos_dec;
  logic w_fast;
  logic w_trigger;

  assign w_pos_dec = decision_valid && stimulation;
`ifdef STIM_FASTPATH_EN
  assign w_fast = decision_valid && (count == 2'd3);
`else
  // Unanimous-vote shortcut is compiled out; count has no effect.
  assign w_fast = 1'b0 && (count == 2'd3);
`endif
  assign w_trigger = w_fast || (w_pos_dec && (r_confirm == 4'(CONFIRM_N - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= 16'd0;
      r_confirm     <= 4'd0;
      r_pulse       <= 8'd0;
      r_pos         <= 1'b0;
      r_neg         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_train_count <= 16'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_CONFIRM: begin
          if (w_trigger) begin
            r_state   <= S_POS;
            r_timer   <= 16'(PULSE_W - 1);
            r_pos     <= 1'b1;
            r_busy    <= 1'b1;
            r_confirm <= 4'd0;
            r_pulse   <= 8'd0;
          end else if (w_pos_dec) begin
            r_confirm <= r_confirm + 4'd1;
            r_state   <= S_CONFIRM;
          end else if (decision_valid) begin
            r_confirm <= 4'd0;
            r_state   <= S_IDLE;
          end
        end
        S_POS: begin
          if (r_timer == 16'd0) begin
            r_state <= S_GAP;
            r_pos   <= 1'b0;
            r_timer <= 16'(GAP_W - 1);
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_GAP: begin
          if (r_timer == 16'd0) begin
            r_state <= S_NEG;
            r_neg   <= 1'b1;
            r_timer <= 16'(PULSE_W - 1);
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_NEG: begin
          if (r_timer == 16'd0) begin
            r_neg <= 1'b0;
            if (r_pulse == 8'(PULSE_CNT - 1)) begin
              r_state <= S_REFRACT;
              r_timer <= 16'(REFRACT_W - 1);
              r_done  <= 1'b1;
              if (r_train_count != 16'hFFFF) begin
                r_train_count <= r_train_count + 16'd1;
              end
            end else begin
              r_state <= S_IPI;
              r_timer <= 16'(IPI_W - 1);
              r_pulse <= r_pulse + 8'd1;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_IPI: begin
          if (r_timer == 16'd0) begin
            r_state <= S_POS;
            r_pos   <= 1'b1;
            r_timer <= 16'(PULSE_W - 1);
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_REFRACT: begin
          // Inputs on the exit edge are deliberately dropped; counting restarts afterwards.
          if (r_timer == 16'd0) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_confirm <= 4'd0;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_timer   <= 16'd0;
          r_confirm <= 4'd0;
          r_pulse   <= 8'd0;
          r_pos     <= 1'b0;
          r_neg     <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign stim_pos    = r_pos;
  assign stim_neg    = r_neg;
  assign busy        = r_busy;
  assign train_done  = r_done;
  assign train_count = r_train_count;

endmodule
